// File: rtl/actuator_pulser.sv
// Fixed-width actuator drive pulse with enforced holdoff gap and a bounded request queue.
// Optional abort input enabled by defining ACTUATOR_PULSER_ABORT_EN.
module actuator_pulser #(
  parameter int PULSE_CYCLES   = 5000000,
  parameter int HOLDOFF_CYCLES = 2000000,
  parameter int CNT_W          = 23,
  parameter int MAX_PENDING    = 7,
  parameter int PEND_W         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
`ifdef ACTUATOR_PULSER_ABORT_EN
  input  logic              abort,
`endif
  output logic              drive,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_PENDING);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              drive_q, drive_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic abort_s;
  logic pulse_last_s;
  logic hold_last_s;
  logic pend_full_s;
  logic pend_empty_s;

`ifdef ACTUATOR_PULSER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign pulse_last_s = (cnt_q == PULSE_LAST);
  assign hold_last_s  = (cnt_q == HOLD_LAST);
  assign pend_full_s  = (pending_q == PEND_MAX);
  assign pend_empty_s = (pending_q == {PEND_W{1'b0}});

  // Next-state, counter, queue and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_PULSE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PULSE: begin
        if (abort_s) begin
          state_d   = ST_HOLDOFF;
          cnt_d     = {CNT_W{1'b0}};
          pending_d = {PEND_W{1'b0}};
        end else begin
          if (pulse_last_s) begin
            state_d = ST_HOLDOFF;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (req && !pend_full_s) begin
            pending_d = pending_q + PEND_W'(1);
          end else if (req) begin
            overflow_d = 1'b1;
          end else begin
            pending_d = pending_q;
          end
        end
      end

      ST_HOLDOFF: begin
        if (abort_s) begin
          pending_d = {PEND_W{1'b0}};
          if (hold_last_s) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (hold_last_s) begin
          // A same-cycle req is counted and dequeued at once, so pending is unchanged.
          cnt_d = {CNT_W{1'b0}};
          if (req) begin
            state_d = ST_PULSE;
          end else if (!pend_empty_s) begin
            state_d   = ST_PULSE;
            pending_d = pending_q - PEND_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (req && !pend_full_s) begin
            pending_d = pending_q + PEND_W'(1);
          end else if (req) begin
            overflow_d = 1'b1;
          end else begin
            pending_d = pending_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    drive_d = (state_d == ST_PULSE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_HOLDOFF) && (cnt_d == HOLD_LAST);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      pending_q  <= {PEND_W{1'b0}};
      overflow_q <= 1'b0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign drive    = drive_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_actuator_pulser.sv
// Directed bench for actuator_pulser with PULSE=4, HOLDOFF=3, MAX_PENDING=2.
// Define ACTUATOR_PULSER_ABORT_EN to also exercise the abort input.
module tb_actuator_pulser;

  localparam int PC = 4;
  localparam int HC = 3;
  localparam int CW = 3;
  localparam int MP = 2;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          drive;
  logic          busy;
  logic [PW-1:0] pending;
  logic          done;
  logic          overflow;
`ifdef ACTUATOR_PULSER_ABORT_EN
  logic          abort;
`endif

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  logic prev_drive = 1'b0;

  actuator_pulser #(
    .PULSE_CYCLES  (PC),
    .HOLDOFF_CYCLES(HC),
    .CNT_W         (CW),
    .MAX_PENDING   (MP),
    .PEND_W        (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
`ifdef ACTUATOR_PULSER_ABORT_EN
    .abort   (abort),
`endif
    .drive   (drive),
    .busy    (busy),
    .pending (pending),
    .done    (done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input string tag, input int c, input logic d, input logic b,
                        input logic dn, input logic [PW-1:0] p, input logic o);
    check_val($sformatf("%s_drive_c%0d", tag, c), 32'(drive), 32'(d));
    check_val($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(b));
    check_val($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(dn));
    check_val($sformatf("%s_pending_c%0d", tag, c), 32'(pending), 32'(p));
    check_val($sformatf("%s_overflow_c%0d", tag, c), 32'(overflow), 32'(o));
    if (drive && !prev_drive) pulses++;
    prev_drive = drive;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
`ifdef ACTUATOR_PULSER_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    prev_drive = 1'b0;
  endtask

  function automatic logic in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  initial begin
    logic [PW-1:0] p;

    // Single request.
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      req = (c == 0);
      sample("single", c, in_rng(c, 1, 4), in_rng(c, 1, 7), c == 7, 2'd0, 1'b0);
      tick();
    end
    check_val("single_pulses", 32'(pulses), 32'd1);

    // Three requests, two queued.
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      req = (c == 0) || (c == 2) || (c == 3);
      p = (c == 3) ? 2'd1 : in_rng(c, 4, 7) ? 2'd2 : in_rng(c, 8, 14) ? 2'd1 : 2'd0;
      sample("queued", c, in_rng(c, 1, 4) || in_rng(c, 8, 11) || in_rng(c, 15, 18),
             in_rng(c, 1, 21), (c == 7) || (c == 14) || (c == 21), p, 1'b0);
      tick();
    end
    check_val("queued_pulses", 32'(pulses), 32'd3);

    // Fourth request overflows the queue.
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      req = (c <= 3);
      p = (c == 2) ? 2'd1 : in_rng(c, 3, 7) ? 2'd2 : in_rng(c, 8, 14) ? 2'd1 : 2'd0;
      sample("ovf", c, in_rng(c, 1, 4) || in_rng(c, 8, 11) || in_rng(c, 15, 18),
             in_rng(c, 1, 21), (c == 7) || (c == 14) || (c == 21), p, c >= 4);
      tick();
    end
    check_val("ovf_pulses", 32'(pulses), 32'd3);

    // Queue full, req on the last holdoff cycle: net zero, no overflow.
    do_reset();
    for (int c = 0; c <= 29; c++) begin
      req = (c <= 2) || (c == 7);
      p = (c == 2) ? 2'd1 : in_rng(c, 3, 14) ? 2'd2 : in_rng(c, 15, 21) ? 2'd1 : 2'd0;
      sample("simul", c,
             in_rng(c, 1, 4) || in_rng(c, 8, 11) || in_rng(c, 15, 18) || in_rng(c, 22, 25),
             in_rng(c, 1, 28), (c == 7) || (c == 14) || (c == 21) || (c == 28), p, 1'b0);
      tick();
    end
    check_val("simul_pulses", 32'(pulses), 32'd4);

    // Empty queue, req on the last holdoff cycle: straight back to PULSE.
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      req = (c == 0) || (c == 7);
      sample("simul0", c, in_rng(c, 1, 4) || in_rng(c, 8, 11), in_rng(c, 1, 14),
             (c == 7) || (c == 14), 2'd0, 1'b0);
      tick();
    end
    check_val("simul0_pulses", 32'(pulses), 32'd2);

    // Reset mid-pulse with a queued request and a same-cycle req.
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      rst = (c == 2);
      req = (c <= 2) || (c == 4);
      sample("rstmid", c, in_rng(c, 1, 2) || in_rng(c, 5, 8),
             in_rng(c, 1, 2) || in_rng(c, 5, 11), c == 11, (c == 2) ? 2'd1 : 2'd0, 1'b0);
      tick();
    end
    rst = 1'b0;
    check_val("rstmid_pulses", 32'(pulses), 32'd2);

`ifdef ACTUATOR_PULSER_ABORT_EN
    // Abort during PULSE, with a same-cycle req that must be dropped.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      req   = (c <= 2);
      abort = (c == 2);
      sample("abort_p", c, in_rng(c, 1, 2), in_rng(c, 1, 5), c == 5,
             (c == 2) ? 2'd1 : 2'd0, 1'b0);
      tick();
    end
    abort = 1'b0;

    // Abort during HOLDOFF clears the queue; holdoff runs to full length.
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      req   = (c <= 1);
      abort = (c == 6);
      sample("abort_h", c, in_rng(c, 1, 4), in_rng(c, 1, 7), c == 7,
             in_rng(c, 2, 6) ? 2'd1 : 2'd0, 1'b0);
      tick();
    end
    abort = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
